// File: rtl/bcd_quad_pkg.sv
// Shared types and BCD helpers for the quadrature encoder emulator.
// Digit arithmetic and detent direction selection live here.
package bcd_quad_pkg;

  typedef enum logic [1:0] {
    IDLE,
    STEP,
    FIN
  } state_t;

  typedef enum logic {
    CW,
    CCW
  } dir_t;

  function automatic logic bcd_valid(input logic [7:0] v);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
  endfunction

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [3:0] t;
    logic [3:0] u;
    t = v[7:4];
    u = v[3:0];
    if (u == 4'd9) begin
      u = 4'd0;
      t = (t == 4'd9) ? 4'd0 : t + 4'd1;
    end else begin
      u = u + 4'd1;
    end
    return {t, u};
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    logic [3:0] t;
    logic [3:0] u;
    t = v[7:4];
    u = v[3:0];
    if (u == 4'd0) begin
      u = 4'd9;
      t = (t == 4'd0) ? 4'd9 : t - 4'd1;
    end else begin
      u = u - 4'd1;
    end
    return {t, u};
  endfunction

  function automatic logic [6:0] bcd2bin(input logic [7:0] v);
    return ({3'd0, v[7:4]} * 7'd10) + {3'd0, v[3:0]};
  endfunction

  // Shortest way round the 00..99 dial; a half-turn tie goes CW.
  function automatic dir_t dir_of(input logic [7:0] tgt,
                                  input logic [7:0] pos);
    logic [6:0] tb;
    logic [6:0] pb;
    logic [6:0] d;
    tb = bcd2bin(tgt);
    pb = bcd2bin(pos);
    if (tb >= pb) d = tb - pb;
    else d = 7'd100 - (pb - tb);
    return (d <= 7'd50) ? CW : CCW;
  endfunction

  // Next a/b pattern for the edge leaving the given phase.
  function automatic logic [1:0] quad_ab(input dir_t dir,
                                         input logic [1:0] ph);
    logic [1:0] ab;
    unique case (ph)
      2'd0: ab = 2'b10;
      2'd1: ab = 2'b11;
      2'd2: ab = 2'b01;
      default: ab = 2'b00;
    endcase
    return (dir == CW) ? ab : {ab[0], ab[1]};
  endfunction

endpackage

// File: rtl/edge_tick.sv
// Edge pacing timer: one-cycle tick every CLKS_PER_EDGE enabled cycles.
// Held at zero while disabled so the first tick is a full period away.
module edge_tick #(
  parameter int CLKS_PER_EDGE = 5000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  output logic tick
);

  localparam int W = $clog2(CLKS_PER_EDGE);
  localparam logic [W-1:0] LAST = W'(CLKS_PER_EDGE - 1);

  logic [W-1:0] cnt;

  assign tick = en && (cnt == LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (!en || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/bcd2quad.sv
// Quadrature encoder emulator: walks a/b from bcd_pos to a BCD target.
// Four Gray edges per detent; position updates on the return to ab=00.
module bcd2quad
  import bcd_quad_pkg::*;
#(
  parameter int CLKS_PER_EDGE = 5000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       load,
  input  logic [7:0] bcd_target,
  output logic       a,
  output logic       b,
  output logic [7:0] bcd_pos,
  output logic       busy,
  output logic       done
);

  state_t     state;
  dir_t       dir;
  logic [1:0] phase;
  logic [7:0] target;
  logic       pend;
  logic       tick;
  logic       tgt_ok;
  logic [7:0] tgt_nxt;
  logic [7:0] pos_nxt;

  assign busy = (state == STEP);
  assign done = (state == FIN);

  assign tgt_ok  = load && bcd_valid(bcd_target);
  assign tgt_nxt = tgt_ok ? bcd_target : target;
  assign pos_nxt = (dir == CW) ? bcd_inc(bcd_pos) : bcd_dec(bcd_pos);

  edge_tick #(
    .CLKS_PER_EDGE(CLKS_PER_EDGE)
  ) u_tick (
    .clk    (clk),
    .reset_n(reset_n),
    .en     (busy),
    .tick   (tick)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      dir     <= CW;
      phase   <= 2'd0;
      target  <= 8'h00;
      pend    <= 1'b0;
      a       <= 1'b0;
      b       <= 1'b0;
      bcd_pos <= 8'h00;
    end else begin
      unique case (state)
        IDLE: begin
          if (tgt_ok || pend) begin
            target <= tgt_nxt;
            pend   <= 1'b0;
            phase  <= 2'd0;
            if (tgt_nxt == bcd_pos) begin
              state <= FIN;
            end else begin
              state <= STEP;
              dir   <= dir_of(tgt_nxt, bcd_pos);
            end
          end
        end
        STEP: begin
          if (tgt_ok) target <= bcd_target;
          if (tick) begin
            {a, b} <= quad_ab(dir, phase);
            phase  <= phase + 2'd1;
            // Detent boundary: the only point a retarget can turn us.
            if (phase == 2'd3) begin
              bcd_pos <= pos_nxt;
              if (pos_nxt == tgt_nxt) state <= FIN;
              else dir <= dir_of(tgt_nxt, pos_nxt);
            end
          end
        end
        FIN: begin
          state <= IDLE;
          if (tgt_ok) begin
            target <= bcd_target;
            pend   <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd2quad.sv
// Scoreboard bench for bcd2quad with a 4-clock edge period.
// Expected edges/done pulses are queued at load and matched in order.
module tb_bcd2quad;

  localparam int CPE = 4;

  typedef struct {
    bit         is_done;
    logic [1:0] ab;
    logic [7:0] pos;
  } ev_t;

  logic       clk;
  logic       reset_n;
  logic       load;
  logic [7:0] bcd_target;
  logic       a;
  logic       b;
  logic [7:0] bcd_pos;
  logic       busy;
  logic       done;

  ev_t        q[$];
  int         n_checks = 0;
  int         n_err = 0;
  int         cyc = 0;
  int         load_cyc = 0;
  int         last_edge = 0;
  int         done_cyc = 0;
  bit         first_edge = 0;
  int         m_pos = 0;
  logic [1:0] prev_ab = 2'b00;

  bcd2quad #(
    .CLKS_PER_EDGE(CPE)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (load),
    .bcd_target(bcd_target),
    .a         (a),
    .b         (b),
    .bcd_pos   (bcd_pos),
    .busy      (busy),
    .done      (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] to_bcd(input int n);
    return 8'(((n / 10) * 16) + (n % 10));
  endfunction

  task automatic push_detent(input bit cw);
    logic [1:0] seq [4];
    seq[0] = cw ? 2'b10 : 2'b01;
    seq[1] = 2'b11;
    seq[2] = cw ? 2'b01 : 2'b10;
    seq[3] = 2'b00;
    m_pos = cw ? (m_pos + 1) % 100 : (m_pos + 99) % 100;
    for (int i = 0; i < 4; i++) begin
      q.push_back('{is_done: 1'b0, ab: seq[i],
                    pos: (i == 3) ? to_bcd(m_pos) : to_bcd((cw ? m_pos + 99 : m_pos + 1) % 100)});
    end
  endtask

  task automatic push_move(input int t);
    int d;
    while (m_pos != t) begin
      d = (t - m_pos + 100) % 100;
      push_detent(d <= 50);
    end
    q.push_back('{is_done: 1'b1, ab: 2'b00, pos: to_bcd(m_pos)});
  endtask

  // Caller is at a negedge; load is sampled on the following posedge.
  task automatic pulse(input logic [7:0] t, input bit fresh);
    load = 1'b1;
    bcd_target = t;
    if (fresh) begin
      first_edge = 1'b1;
      load_cyc = cyc + 1;
    end
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    check("timeout", q.size(), 0);
    @(negedge clk);
    check("busy_end", busy, 0);
  endtask

  // Output monitor: Gray steps, BCD sanity, event order and timing.
  initial forever begin
    ev_t e;
    @(negedge clk);
    if (!reset_n) begin
      prev_ab = {a, b};
    end else begin
      check("pos_bcd", (bcd_pos[7:4] <= 4'd9) && (bcd_pos[3:0] <= 4'd9), 1);
      if ({a, b} != prev_ab) begin
        check("gray", $countones({a, b} ^ prev_ab), 1);
        if (q.size() == 0) begin
          check("unexp_edge", q.size(), 1);
        end else begin
          e = q.pop_front();
          check("kind_edge", e.is_done, 0);
          check("ab", {a, b}, e.ab);
          check("pos", bcd_pos, e.pos);
          if (first_edge) check("first_gap", cyc - load_cyc, CPE);
          else check("edge_gap", cyc - last_edge, CPE);
        end
        first_edge = 1'b0;
        last_edge = cyc;
        prev_ab = {a, b};
      end
      if (done) begin
        check("done_busy", busy, 0);
        if (q.size() == 0) begin
          check("unexp_done", q.size(), 1);
        end else begin
          e = q.pop_front();
          check("kind_done", e.is_done, 1);
          check("done_pos", bcd_pos, e.pos);
        end
        done_cyc = cyc;
        first_edge = 1'b1;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset_n = 1'b0;
    load = 1'b0;
    bcd_target = 8'h00;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_ab", {a, b}, 2'b00);
    check("rst_pos", bcd_pos, 8'h00);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);

    pulse(8'h5A, 0);
    repeat (8) @(negedge clk);
    check("inv_5A_busy", busy, 0);
    check("inv_5A_pos", bcd_pos, 8'h00);
    pulse(8'hA0, 0);
    repeat (8) @(negedge clk);
    check("inv_A0_busy", busy, 0);
    check("inv_A0_pos", bcd_pos, 8'h00);

    push_move(0);
    pulse(8'h00, 1);
    wait_idle(20);

    push_move(3);
    pulse(8'h03, 1);
    wait_idle(200);
    check("done_lat", done_cyc - load_cyc, 12 * CPE);

    // Wrap and tie cases, each target chained from the last.
    push_move(0);  pulse(8'h00, 1); wait_idle(200);
    push_move(98); pulse(8'h98, 1); wait_idle(200);
    check("pos_98", bcd_pos, 8'h98);
    push_move(99); pulse(8'h99, 1); wait_idle(200);
    push_move(1);  pulse(8'h01, 1); wait_idle(200);
    check("pos_01", bcd_pos, 8'h01);
    push_move(0);  pulse(8'h00, 1); wait_idle(200);
    push_move(50); pulse(8'h50, 1); wait_idle(2000);
    check("pos_50", bcd_pos, 8'h50);
    push_move(0);  pulse(8'h00, 1); wait_idle(2000);

    // Retarget mid-detent after reaching 02.
    push_detent(1);
    push_detent(1);
    push_detent(1);
    push_move(1);
    pulse(8'h05, 1);
    n = 0;
    while (!(bcd_pos == 8'h02 && {a, b} == 2'b10) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("rt_wait", n < 200, 1);
    pulse(8'h01, 0);
    wait_idle(400);
    check("rt_pos", bcd_pos, 8'h01);

    push_move(0);  pulse(8'h00, 1); wait_idle(200);

    // Load arriving during the done cycle is held over.
    push_move(2);
    push_move(1);
    pulse(8'h02, 1);
    n = 0;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("fin_wait", n < 200, 1);
    pulse(8'h01, 1);
    load_cyc = load_cyc + 1;
    wait_idle(200);
    check("fin_pos", bcd_pos, 8'h01);

    // Asynchronous reset in the middle of a move.
    push_move(10);
    pulse(8'h10, 1);
    repeat (10) @(negedge clk);
    #1 reset_n = 1'b0;
    #1;
    check("mid_rst_ab", {a, b}, 2'b00);
    check("mid_rst_pos", bcd_pos, 8'h00);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    q.delete();
    m_pos = 0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (40) @(negedge clk);
    check("post_rst_ab", {a, b}, 2'b00);
    check("post_rst_pos", bcd_pos, 8'h00);
    check("post_rst_busy", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
